// File: rtl/gpio_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input front end and the TL-UL GPIO slave.
// Both blocks import this package so the pin count and debounce counter
// width stay consistent across the subsystem.
//
// Contents:
//   GPIO_WIDTH    number of GPIO pins handled by the slave (16)
//   GPIO_DB_CW    default debounce counter / threshold width (8)
//   GPIO_SYNC     default synchroniser depth (2)
//   gpio_vec_t    one bit per GPIO pin
//   gpio_db_cnt_t debounce counter / threshold value
// ---------------------------------------------------------------------------
package gpio_pkg;

  localparam int GPIO_WIDTH = 16;
  localparam int GPIO_DB_CW = 8;
  localparam int GPIO_SYNC  = 2;

  typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;
  typedef logic [GPIO_DB_CW-1:0] gpio_db_cnt_t;

endpackage : gpio_pkg

// File: rtl/gpio_pin_debounce.sv
// ---------------------------------------------------------------------------
// gpio_pin_debounce
// Single-pin front end: a metastability synchroniser chain followed by an
// optional debouncer that only commits a new level once the synchronised
// input has disagreed with the committed level for threshold+1 consecutive
// cycles.
//
// Parameters:
//   SYNC_STAGES  flops in the synchroniser chain (2 or more)
//   DB_CW        debounce counter / threshold width
//
// Ports:
//   clk           block clock
//   rst_n         asynchronous active-low reset, clears every flop to 0
//   pin           raw asynchronous pad input
//   db_enable     debounce enable for this pin (quasi-static)
//   db_threshold  shared debounce threshold T (quasi-static)
//   level         committed (conditioned) pin level
// ---------------------------------------------------------------------------
module gpio_pin_debounce
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = GPIO_SYNC,
  parameter int DB_CW       = GPIO_DB_CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic             db_enable,
  input  logic [DB_CW-1:0] db_threshold,
  output logic             level
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   synced;
  logic [DB_CW-1:0]       cnt_reg;
  logic [DB_CW-1:0]       cnt_next;
  logic                   level_reg;
  logic                   level_next;

  // Shift register synchroniser; bit 0 is the first flop off the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  // The counter tracks how many consecutive cycles the synchronised input
  // has already disagreed with the committed level. Commit happens on the
  // cycle the count has reached T, so T+1 mismatching cycles are required.
  // Using >= means a threshold lowered below an in-flight count commits on
  // the very next mismatch, and the counter can never wrap.
  always_comb begin
    level_next = level_reg;
    cnt_next   = cnt_reg;
    if (!db_enable) begin
      level_next = synced;
      cnt_next   = '0;
    end else if (synced == level_reg) begin
      cnt_next   = '0;
    end else if (cnt_reg >= db_threshold) begin
      level_next = synced;
      cnt_next   = '0;
    end else begin
      cnt_next   = cnt_reg + DB_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign level = level_reg;

endmodule : gpio_pin_debounce

// File: rtl/gpio_input_conditioner.sv
// ---------------------------------------------------------------------------
// gpio_input_conditioner
// Per-pin input front end for the TL-UL GPIO slave. Each pad is synchronised
// and optionally debounced; the resulting clean levels drive the slave's
// inputs_i bus. Edges on the conditioned levels can be captured into sticky
// pending bits that raise a level interrupt.
//
// Build option:
//   GPIO_INPUT_EDGE_IRQ_EN  when defined, edge detection, pending_o and irq_o
//                           are implemented; when undefined they are compiled
//                           out, pending_o/irq_o read 0 and the edge controls
//                           are ignored. inputs_o is identical in both builds.
//
// Parameters:
//   WIDTH        number of GPIO input pins
//   SYNC_STAGES  synchroniser depth per pin (2 or more)
//   DB_CW        debounce counter / threshold width
//
// Ports:
//   gpio_clock_i    block clock
//   gpio_reset_ni   asynchronous active-low reset
//   pins_i          raw asynchronous pad inputs
//   db_enable_i     per-pin debounce enable (quasi-static)
//   db_threshold_i  shared debounce threshold T (quasi-static)
//   rise_en_i       per-pin rising-edge capture enable
//   fall_en_i       per-pin falling-edge capture enable
//   pending_clr_i   one-cycle write-1-to-clear mask for pending bits
//   inputs_o        conditioned pin levels
//   pending_o       sticky edge-pending flags
//   irq_o           high while any pending bit is set
// ---------------------------------------------------------------------------
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH,
  parameter int SYNC_STAGES = GPIO_SYNC,
  parameter int DB_CW       = GPIO_DB_CW
) (
  input  logic             gpio_clock_i,
  input  logic             gpio_reset_ni,
  input  logic [WIDTH-1:0] pins_i,
  input  logic [WIDTH-1:0] db_enable_i,
  input  logic [DB_CW-1:0] db_threshold_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] pending_clr_i,
  output logic [WIDTH-1:0] inputs_o,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] level;

  // One independent synchroniser + debouncer per pin.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      gpio_pin_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CW       (DB_CW)
      ) u_pin_debounce (
        .clk          (gpio_clock_i),
        .rst_n        (gpio_reset_ni),
        .pin          (pins_i[gi]),
        .db_enable    (db_enable_i[gi]),
        .db_threshold (db_threshold_i),
        .level        (level[gi])
      );
    end
  endgenerate

  assign inputs_o = level;

`ifdef GPIO_INPUT_EDGE_IRQ_EN

  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] pending_reg;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             irq_reg;

  // prev resets to 0, so a level that is already high once the pipeline
  // fills looks like a rising edge; that is intended.
  always_comb begin
    rise         = level & ~prev_reg & rise_en_i;
    fall         = ~level & prev_reg & fall_en_i;
    // New edges are ORed in after the clear so a same-cycle set wins.
    pending_next = (pending_reg & ~pending_clr_i) | rise | fall;
  end

  always_ff @(posedge gpio_clock_i or negedge gpio_reset_ni) begin
    if (!gpio_reset_ni) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      irq_reg     <= 1'b0;
    end else begin
      prev_reg    <= level;
      pending_reg <= pending_next;
      // Registered from the next pending value so irq_o tracks pending_o
      // cycle for cycle instead of lagging it.
      irq_reg     <= |pending_next;
    end
  end

  assign pending_o = pending_reg;
  assign irq_o     = irq_reg;

`else

  // Edge controls are deliberately ignored in this build; the reduction
  // keeps them referenced under a name lint treats as intentionally unused.
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{rise_en_i, fall_en_i, pending_clr_i};

  assign pending_o = '0;
  assign irq_o     = 1'b0;

`endif

endmodule : gpio_input_conditioner

// File: tb/tb_gpio_input_conditioner.sv
module tb_gpio_input_conditioner;
  localparam int W  = 16;
  localparam int SS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  pins = '1;
  logic [W-1:0]  db_en = '0;
  logic [CW-1:0] thr = '0;
  logic [W-1:0]  rise_en = '0;
  logic [W-1:0]  fall_en = '0;
  logic [W-1:0]  clr = '0;
  logic [W-1:0]  inputs;
  logic [W-1:0]  pending;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_sync [SS];
  int           m_streak [W];
  logic [W-1:0] m_level, m_prev, m_pend;
  logic         m_irq;

  always #5 clk = ~clk;

  gpio_input_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DB_CW(CW)) dut (
    .gpio_clock_i   (clk),
    .gpio_reset_ni  (rst_n),
    .pins_i         (pins),
    .db_enable_i    (db_en),
    .db_threshold_i (thr),
    .rise_en_i      (rise_en),
    .fall_en_i      (fall_en),
    .pending_clr_i  (clr),
    .inputs_o       (inputs),
    .pending_o      (pending),
    .irq_o          (irq)
  );

  task automatic model_reset();
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    for (int i = 0; i < W; i++) m_streak[i] = 0;
    m_level = '0; m_prev = '0; m_pend = '0; m_irq = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input string tag);
    logic [W-1:0] synced, nl, rise, fall, pnext;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      synced = m_sync[SS-1];
      nl     = m_level;
      for (int i = 0; i < W; i++) begin
        if (!db_en[i]) begin
          nl[i] = synced[i];
          m_streak[i] = 0;
        end else begin
          // T+1 consecutive disagreeing cycles are needed to commit
          m_streak[i] = (synced[i] != m_level[i]) ? m_streak[i] + 1 : 0;
          if (m_streak[i] > int'(thr)) begin
            nl[i] = synced[i];
            m_streak[i] = 0;
          end
        end
      end
      rise  = m_level & ~m_prev & rise_en;
      fall  = ~m_level & m_prev & fall_en;
      pnext = (m_pend & ~clr) | rise | fall;
`ifdef GPIO_INPUT_EDGE_IRQ_EN
      m_pend = pnext;
      m_irq  = (pnext != '0);
`endif
      m_prev  = m_level;
      m_level = nl;
      for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
      m_sync[0] = pins;
    end
    #1;
    checks++;
    if (inputs !== m_level || pending !== m_pend || irq !== m_irq) begin
      errors++;
      $display("FAIL model_%s: got inputs=%h pending=%h irq=%b expected inputs=%h pending=%h irq=%b",
               tag, inputs, pending, irq, m_level, m_pend, m_irq);
    end
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    rst_n = 1'b0; pins = '1; db_en = '0; thr = '0;
    #1;
    checks++;
    if (inputs !== '0 || pending !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got inputs=%h pending=%h irq=%b expected 0", inputs, pending, irq);
    end
    repeat (4) step("in_reset");
    rst_n = 1'b1;
    n = 0;
    while (inputs !== 16'hFFFF && n < 10) begin
      step("reset_release");
      n++;
    end
    checks++;
    if (n != 3 || inputs !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_latency: got %0d clocks inputs=%h expected 3 clocks inputs=ffff", n, inputs);
    end
    $display("reset: release-to-output latency %0d clocks", n);
  endtask

  task automatic test_debounce_length();
    int n;
    pins = '0; db_en = 16'h0008; thr = 8'd4;
    repeat (10) step("db_settle");
    pins[3] = 1'b1;
    n = 0;
    while (inputs[3] !== 1'b1 && n < 20) begin
      step("db_len");
      n++;
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL debounce_length: got %0d clocks expected 7", n);
    end
    $display("debounce_length: pin3 T=4 latency %0d clocks", n);
  endtask

  task automatic test_glitch();
    bit seen_high;
    pins[3] = 1'b0;
    repeat (10) step("glitch_settle");
    pins[3] = 1'b1;
    repeat (3) step("glitch3");
    pins[3] = 1'b0;
    seen_high = 1'b0;
    repeat (12) begin
      step("glitch3_tail");
      if (inputs[3] === 1'b1) seen_high = 1'b1;
    end
    checks++;
    if (seen_high) begin
      errors++;
      $display("FAIL glitch_reject: got inputs[3]=1 during 3-cycle pulse expected 0");
    end
    $display("glitch: 3-cycle pulse seen_high=%0b", seen_high);
    pins[3] = 1'b1;
    repeat (5) begin
      step("glitch5");
      if (inputs[3] === 1'b1) seen_high = 1'b1;
    end
    pins[3] = 1'b0;
    repeat (12) begin
      step("glitch5_tail");
      if (inputs[3] === 1'b1) seen_high = 1'b1;
    end
    checks++;
    if (!seen_high) begin
      errors++;
      $display("FAIL glitch_accept: got inputs[3] never 1 for 5-cycle pulse expected 1");
    end
    $display("glitch: 5-cycle pulse seen_high=%0b", seen_high);
  endtask

`ifdef GPIO_INPUT_EDGE_IRQ_EN
  task automatic test_edges();
    clr = '1; step("edge_preclr"); clr = '0;
    rise_en = 16'h0001; fall_en = '0;
    pins[0] = 1'b1;
    repeat (3) step("edge_rise");
    checks++;
    if (pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL edge_early: got pending[0]=%b expected 0", pending[0]);
    end
    step("edge_capture");
    checks++;
    if (pending[0] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL edge_set: got pending[0]=%b irq=%b expected 1 1", pending[0], irq);
    end
    pins[0] = 1'b0;
    repeat (6) step("edge_fall");
    checks++;
    if (pending !== 16'h0001) begin
      errors++;
      $display("FAIL edge_rise_only: got pending=%h expected 0001", pending);
    end
    clr = 16'h0001; step("edge_clr"); clr = '0;
    checks++;
    if (pending !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_clear: got pending=%h irq=%b expected 0000 0", pending, irq);
    end
    $display("edges: rise captured and cleared on pin 0");
  endtask

  task automatic test_set_beats_clear();
    rise_en = 16'h0020; fall_en = '0;
    pins[5] = 1'b1;
    repeat (3) step("sbc_rise");
    clr[5] = 1'b1;
    step("sbc_clr");
    clr = '0;
    checks++;
    if (pending[5] !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: got pending[5]=%b irq=%b expected 1 1", pending[5], irq);
    end
    clr = 16'h0020; step("sbc_clr2"); clr = '0;
    pins[5] = 1'b0;
    repeat (4) step("sbc_settle");
    $display("set_beats_clear: pending[5] survived same-cycle clear");
  endtask
`else
  task automatic test_edges_disabled();
    rise_en = '1; fall_en = '1;
    pins[0] = 1'b1;
    repeat (6) step("noirq_rise");
    pins[0] = 1'b0;
    repeat (6) step("noirq_fall");
    checks++;
    if (pending !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL edges_disabled: got pending=%h irq=%b expected 0000 0", pending, irq);
    end
    rise_en = '0; fall_en = '0;
    $display("edges_disabled: pending and irq held at zero");
  endtask
`endif

  task automatic test_threshold_drop();
    int n;
    db_en[7] = 1'b1; thr = 8'd200;
    pins[7] = 1'b1;
    repeat (52) step("thr_hold");
    checks++;
    if (inputs[7] !== 1'b0) begin
      errors++;
      $display("FAIL thr_hold: got inputs[7]=%b expected 0", inputs[7]);
    end
    thr = 8'd10;
    step("thr_drop");
    checks++;
    if (inputs[7] !== 1'b1) begin
      errors++;
      $display("FAIL thr_drop: got inputs[7]=%b expected 1", inputs[7]);
    end
    pins[7] = 1'b0;
    n = 0;
    while (inputs[7] !== 1'b0 && n < 40) begin
      step("thr_restart");
      n++;
    end
    checks++;
    if (n != 13) begin
      errors++;
      $display("FAIL thr_restart: got %0d clocks expected 13", n);
    end
    $display("threshold_drop: committed after drop, restart latency %0d", n);
  endtask

  task automatic test_async_reset();
    pins = $urandom; db_en = '0; rise_en = '1; fall_en = '1;
    repeat (5) step("ar_pre");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (inputs !== '0 || pending !== '0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got inputs=%h pending=%h irq=%b expected 0", inputs, pending, irq);
    end
    repeat (2) step("ar_hold");
    rst_n = 1'b1;
    repeat (5) step("ar_post");
    $display("async_reset: state discarded mid-operation");
  endtask

  task automatic test_random();
    for (int b = 0; b < 30; b++) begin
      db_en   = $urandom;
      thr     = CW'($urandom_range(0, 5));
      rise_en = $urandom;
      fall_en = $urandom;
      for (int c = 0; c < 50; c++) begin
        for (int i = 0; i < W; i++)
          if ($urandom_range(0, 5) == 0) pins[i] = ~pins[i];
        clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
        step("random");
      end
    end
    clr = '0;
    $display("random: 1500 cycles compared against model");
  endtask

  initial begin
    test_reset();
    test_debounce_length();
    test_glitch();
`ifdef GPIO_INPUT_EDGE_IRQ_EN
    test_edges();
    test_set_beats_clear();
`else
    test_edges_disabled();
`endif
    test_threshold_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpio_input_conditioner
